multicycle_control: RTL and testbench

Multi-cycle sequencing FSM for the RV32 subset core (R-type and/or/add/sub, addi, lw, sw, beq/blt/bge, jal, jalr). It steps each instruction through fetch, decode, execute, memory and writeback. It issues the 3-bit ALU operation code and drives the PC, instruction register, register file and memory enables. It sits between the instruction register and the shared ALU and memory port, and handshakes with memory via mem_ready.

---
 rtl/multicycle_control_if.sv | 43 ++++
 rtl/multicycle_control.sv | 200 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_if
// Purpose  : Control/status bundle between the multi-cycle sequencer and the
//            RV32 datapath (IR fields, memory handshake, datapath enables).
// Revision : 1.0
// ============================================================================
interface multicycle_control_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       opcode;
    logic [2:0]       func3;
    logic [6:0]       func7;
    logic             mem_ready;
    logic             branch_taken;
    logic             pc_we;
    logic [1:0]       pc_sel;
    logic             ir_we;
    logic             reg_we;
    logic [1:0]       wb_sel;
    logic             mem_re;
    logic             mem_we;
    logic             addr_sel;
    logic             alu_src_imm;
    logic [2:0]       alu_ctrl;
    logic [2:0]       state;
    logic             illegal;
    logic             bus_err;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode, func3, func7, mem_ready, branch_taken,
        output pc_we, pc_sel, ir_we, reg_we, wb_sel, mem_re, mem_we,
               addr_sel, alu_src_imm, alu_ctrl, state, illegal, bus_err, retired
    );

    modport slave (
        output opcode, func3, func7, mem_ready, branch_taken,
        input  pc_we, pc_sel, ir_we, reg_we, wb_sel, mem_re, mem_we,
               addr_sel, alu_src_imm, alu_ctrl, state, illegal, bus_err, retired
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Purpose  : Fetch/decode/execute/memory/writeback sequencer for the RV32
//            subset core, with memory timeout and retired-instruction count.
// Revision : 1.0
// ============================================================================
module multicycle_control #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  wire logic              clk,
    input  wire logic              rst,
    multicycle_control_if.master   bus
);
    localparam int TO_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TO_W-1:0] c_TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    localparam logic [2:0] c_ST_FETCH  = 3'd0;
    localparam logic [2:0] c_ST_DECODE = 3'd1;
    localparam logic [2:0] c_ST_EXEC   = 3'd2;
    localparam logic [2:0] c_ST_MEM    = 3'd3;
    localparam logic [2:0] c_ST_WB     = 3'd4;
    localparam logic [2:0] c_ST_BRANCH = 3'd5;
    localparam logic [2:0] c_ST_TRAP   = 3'd6;

    localparam logic [2:0] c_CL_R    = 3'd0;
    localparam logic [2:0] c_CL_ADDI = 3'd1;
    localparam logic [2:0] c_CL_LW   = 3'd2;
    localparam logic [2:0] c_CL_SW   = 3'd3;
    localparam logic [2:0] c_CL_BR   = 3'd4;
    localparam logic [2:0] c_CL_JAL  = 3'd5;
    localparam logic [2:0] c_CL_JALR = 3'd6;

    logic [2:0]       r_state;
    logic [2:0]       r_cls;
    logic [2:0]       r_alu_ctrl;
    logic             r_illegal;
    logic             r_bus_err;
    logic [CNT_W-1:0] r_retired;
    logic [TO_W-1:0]  r_to_cnt;

    logic [2:0] w_dec_cls;
    logic [2:0] w_dec_alu;
    logic       w_dec_ok;
    logic [2:0] w_next;
    logic       w_set_ill;
    logic       w_set_bus;
    logic       w_timeout;
    logic       w_waiting;

    logic       w_pc_we, w_ir_we, w_reg_we, w_mem_re, w_mem_we, w_addr_sel, w_alu_src_imm;
    logic [1:0] w_pc_sel, w_wb_sel;

    // Instruction class is captured in DECODE so later states ignore IR changes.
    always_comb begin
        w_dec_cls = c_CL_R;
        w_dec_alu = 3'b010;
        w_dec_ok  = 1'b1;
        case (bus.opcode)
            7'b0110011: begin
                case ({bus.func7, bus.func3})
                    {7'b0000000, 3'b000}: w_dec_alu = 3'b010;
                    {7'b0100000, 3'b000}: w_dec_alu = 3'b011;
                    {7'b0000000, 3'b110}: w_dec_alu = 3'b001;
                    {7'b0000000, 3'b111}: w_dec_alu = 3'b000;
                    default:              w_dec_ok  = 1'b0;
                endcase
            end
            7'b0010011: w_dec_cls = c_CL_ADDI;
            7'b0000011: w_dec_cls = c_CL_LW;
            7'b0100011: w_dec_cls = c_CL_SW;
            7'b1101111: w_dec_cls = c_CL_JAL;
            7'b1100111: w_dec_cls = c_CL_JALR;
            7'b1100011: begin
                w_dec_cls = c_CL_BR;
                case (bus.func3)
                    3'b000:  w_dec_alu = 3'b110;
                    3'b100:  w_dec_alu = 3'b100;
                    3'b101:  w_dec_alu = 3'b101;
                    default: w_dec_ok  = 1'b0;
                endcase
            end
            default: w_dec_ok = 1'b0;
        endcase
    end

    assign w_waiting = ((r_state == c_ST_FETCH) || (r_state == c_ST_MEM)) && !bus.mem_ready;
    assign w_timeout = w_waiting && (r_to_cnt == c_TO_LAST);

    always_comb begin
        w_next    = r_state;
        w_set_ill = 1'b0;
        w_set_bus = 1'b0;
        case (r_state)
            c_ST_FETCH: begin
                if (bus.mem_ready) w_next = c_ST_DECODE;
                else if (w_timeout) begin
                    w_next    = c_ST_TRAP;
                    w_set_bus = 1'b1;
                end
            end
            c_ST_DECODE: begin
                if (!w_dec_ok) begin
                    w_next    = c_ST_TRAP;
                    w_set_ill = 1'b1;
                end else if (w_dec_cls == c_CL_BR) w_next = c_ST_BRANCH;
                else                               w_next = c_ST_EXEC;
            end
            c_ST_EXEC:   w_next = ((r_cls == c_CL_LW) || (r_cls == c_CL_SW)) ? c_ST_MEM : c_ST_WB;
            c_ST_MEM: begin
                if (bus.mem_ready) w_next = (r_cls == c_CL_LW) ? c_ST_WB : c_ST_FETCH;
                else if (w_timeout) begin
                    w_next    = c_ST_TRAP;
                    w_set_bus = 1'b1;
                end
            end
            c_ST_WB:     w_next = c_ST_FETCH;
            c_ST_BRANCH: w_next = c_ST_FETCH;
            c_ST_TRAP:   w_next = c_ST_TRAP;
            default:     w_next = c_ST_FETCH;
        endcase
    end

    // Enables are gated by rst so an in-flight request drops the moment reset rises.
    always_comb begin
        w_pc_we = 1'b0; w_pc_sel = 2'b00; w_ir_we = 1'b0; w_reg_we = 1'b0;
        w_wb_sel = 2'b00; w_mem_re = 1'b0; w_mem_we = 1'b0; w_addr_sel = 1'b0;
        w_alu_src_imm = 1'b0;
        if (!rst) begin
            case (r_state)
                c_ST_FETCH: begin
                    w_mem_re = 1'b1;
                    w_ir_we  = bus.mem_ready;
                end
                c_ST_EXEC: w_alu_src_imm = (r_cls == c_CL_ADDI) || (r_cls == c_CL_LW) ||
                                           (r_cls == c_CL_SW)   || (r_cls == c_CL_JALR);
                c_ST_MEM: begin
                    w_addr_sel    = 1'b1;
                    w_alu_src_imm = 1'b1;
                    w_mem_re      = (r_cls == c_CL_LW);
                    w_mem_we      = (r_cls == c_CL_SW);
                    w_pc_we       = (r_cls == c_CL_SW) && bus.mem_ready;
                end
                c_ST_WB: begin
                    w_reg_we = 1'b1;
                    w_pc_we  = 1'b1;
                    if (r_cls == c_CL_LW)                               w_wb_sel = 2'b01;
                    else if ((r_cls == c_CL_JAL) || (r_cls == c_CL_JALR)) w_wb_sel = 2'b10;
                    if (r_cls == c_CL_JAL)       w_pc_sel = 2'b01;
                    else if (r_cls == c_CL_JALR) w_pc_sel = 2'b10;
                end
                c_ST_BRANCH: begin
                    w_pc_we  = 1'b1;
                    w_pc_sel = bus.branch_taken ? 2'b01 : 2'b00;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_ST_FETCH;
            r_cls      <= c_CL_R;
            r_alu_ctrl <= 3'b010;
            r_illegal  <= 1'b0;
            r_bus_err  <= 1'b0;
            r_retired  <= '0;
            r_to_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == c_ST_DECODE) begin
                r_cls      <= w_dec_cls;
                r_alu_ctrl <= w_dec_alu;
            end
            if (w_set_ill) r_illegal <= 1'b1;
            if (w_set_bus) r_bus_err <= 1'b1;
            if (w_pc_we)   r_retired <= r_retired + CNT_W'(1);
            if (w_next != r_state) r_to_cnt <= '0;
            else if (w_waiting)    r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

    assign bus.pc_we       = w_pc_we;
    assign bus.pc_sel      = w_pc_sel;
    assign bus.ir_we       = w_ir_we;
    assign bus.reg_we      = w_reg_we;
    assign bus.wb_sel      = w_wb_sel;
    assign bus.mem_re      = w_mem_re;
    assign bus.mem_we      = w_mem_we;
    assign bus.addr_sel    = w_addr_sel;
    assign bus.alu_src_imm = w_alu_src_imm;
    assign bus.alu_ctrl    = r_alu_ctrl;
    assign bus.state       = r_state;
    assign bus.illegal     = r_illegal;
    assign bus.bus_err     = r_bus_err;
    assign bus.retired     = r_retired;
endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control
// Purpose  : Directed self-checking bench for the multi-cycle sequencer.
// Revision : 1.0
// ============================================================================
module tb_multicycle_control;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    multicycle_control_if #(.CNT_W(32)) bus();

    multicycle_control #(.CNT_W(32), .MEM_TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {state, pc_we, pc_sel, ir_we, reg_we, wb_sel, mem_re, mem_we, addr_sel, alu_src_imm}
    function automatic logic [13:0] mk(input logic [2:0] st, input logic pcwe, input logic [1:0] pcsel,
                                       input logic irwe, input logic regwe, input logic [1:0] wbsel,
                                       input logic re, input logic we, input logic as, input logic imm);
        return {st, pcwe, pcsel, irwe, regwe, wbsel, re, we, as, imm};
    endfunction

    function automatic logic [13:0] obs();
        return {bus.state, bus.pc_we, bus.pc_sel, bus.ir_we, bus.reg_we, bus.wb_sel,
                bus.mem_re, bus.mem_we, bus.addr_sel, bus.alu_src_imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        bus.opcode = op;
        bus.func3  = f3;
        bus.func7  = f7;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        bus.mem_ready = 1'b1;
        bus.branch_taken = 1'b0;
        set_ir(7'b0110011, 3'b000, 7'b0000000);
        #1;
        chk("rst_ctl", 32'(obs()), 32'(mk(0,0,0,0,0,0,0,0,0,0)));
        tick(); tick();
        chk("rst_alu", 32'(bus.alu_ctrl), 32'h2);
        chk("rst_flags", {30'd0, bus.illegal, bus.bus_err}, 32'h0);
        chk("rst_retired", bus.retired, 32'd0);
        rst = 1'b0;

        // add x3,x1,x2
        #1; chk("add_fetch", 32'(obs()), 32'(mk(0,0,0,1,0,0,1,0,0,0)));
        tick(); chk("add_decode", 32'(obs()), 32'(mk(1,0,0,0,0,0,0,0,0,0)));
        tick(); chk("add_exec", 32'(obs()), 32'(mk(2,0,0,0,0,0,0,0,0,0)));
        chk("add_alu", 32'(bus.alu_ctrl), 32'h2);
        tick(); chk("add_wb", 32'(obs()), 32'(mk(4,1,0,0,1,0,0,0,0,0)));
        tick(); chk("add_ret", bus.retired, 32'd1);
        chk("add_back_fetch", 32'(bus.state), 32'd0);

        // sub then or
        set_ir(7'b0110011, 3'b000, 7'b0100000);
        tick(); tick(); chk("sub_alu", 32'(bus.alu_ctrl), 32'h3);
        tick(); chk("sub_wb", 32'(obs()), 32'(mk(4,1,0,0,1,0,0,0,0,0)));
        tick(); set_ir(7'b0110011, 3'b110, 7'b0000000);
        tick(); tick(); chk("or_alu", 32'(bus.alu_ctrl), 32'h1);
        tick(); tick(); chk("or_ret", bus.retired, 32'd3);

        // lw with two wait cycles in FETCH and in MEM
        set_ir(7'b0000011, 3'b010, 7'b0000000);
        bus.mem_ready = 1'b0;
        #1; chk("lw_fwait1", 32'(obs()), 32'(mk(0,0,0,0,0,0,1,0,0,0)));
        tick(); chk("lw_fwait2", 32'(obs()), 32'(mk(0,0,0,0,0,0,1,0,0,0)));
        tick(); bus.mem_ready = 1'b1;
        #1; chk("lw_fready", 32'(obs()), 32'(mk(0,0,0,1,0,0,1,0,0,0)));
        tick(); tick(); chk("lw_exec", 32'(obs()), 32'(mk(2,0,0,0,0,0,0,0,0,1)));
        tick(); bus.mem_ready = 1'b0;
        #1; chk("lw_mwait1", 32'(obs()), 32'(mk(3,0,0,0,0,0,1,0,1,1)));
        tick(); chk("lw_mwait2", 32'(obs()), 32'(mk(3,0,0,0,0,0,1,0,1,1)));
        tick(); bus.mem_ready = 1'b1;
        #1; chk("lw_mready", 32'(obs()), 32'(mk(3,0,0,0,0,0,1,0,1,1)));
        tick(); chk("lw_wb", 32'(obs()), 32'(mk(4,1,0,0,1,1,0,0,0,0)));
        tick(); chk("lw_ret", bus.retired, 32'd4);

        // beq taken, blt not taken
        set_ir(7'b1100011, 3'b000, 7'b0000000);
        bus.branch_taken = 1'b1;
        tick(); tick(); chk("beq_br", 32'(obs()), 32'(mk(5,1,1,0,0,0,0,0,0,0)));
        chk("beq_alu", 32'(bus.alu_ctrl), 32'h6);
        tick(); set_ir(7'b1100011, 3'b100, 7'b0000000);
        bus.branch_taken = 1'b0;
        tick(); tick(); #1; chk("blt_br", 32'(obs()), 32'(mk(5,1,0,0,0,0,0,0,0,0)));
        chk("blt_alu", 32'(bus.alu_ctrl), 32'h4);
        tick(); chk("br_ret", bus.retired, 32'd6);

        // unsupported opcode traps
        set_ir(7'b0110111, 3'b000, 7'b0000000);
        tick(); chk("ill_decode", 32'(obs()), 32'(mk(1,0,0,0,0,0,0,0,0,0)));
        tick(); chk("ill_trap", 32'(obs()), 32'(mk(6,0,0,0,0,0,0,0,0,0)));
        chk("ill_flag", 32'(bus.illegal), 32'd1);
        tick(); tick(); chk("ill_hold", 32'(obs()), 32'(mk(6,0,0,0,0,0,0,0,0,0)));
        rst = 1'b1;
        #1; chk("ill_rst", {bus.state, bus.illegal, bus.bus_err}, 32'h0);
        chk("ill_rst_ret", bus.retired, 32'd0);
        tick(); rst = 1'b0;

        // sw timeout in MEM
        set_ir(7'b0100011, 3'b010, 7'b0000000);
        tick(); tick(); chk("sw_exec", 32'(obs()), 32'(mk(2,0,0,0,0,0,0,0,0,1)));
        tick(); bus.mem_ready = 1'b0;
        #1; chk("sw_mwait", 32'(obs()), 32'(mk(3,0,0,0,0,0,0,1,1,1)));
        tick(); tick(); tick(); chk("sw_mwait4", 32'(obs()), 32'(mk(3,0,0,0,0,0,0,1,1,1)));
        tick(); chk("sw_to_trap", 32'(obs()), 32'(mk(6,0,0,0,0,0,0,0,0,0)));
        chk("sw_bus_err", 32'(bus.bus_err), 32'd1);
        rst = 1'b1;
        tick(); rst = 1'b0;
        bus.mem_ready = 1'b1;

        // sw with mem_ready on the last allowed cycle
        tick(); tick(); tick(); bus.mem_ready = 1'b0;
        tick(); tick(); tick(); bus.mem_ready = 1'b1;
        #1; chk("sw_last_ready", 32'(obs()), 32'(mk(3,1,0,0,0,0,0,1,1,1)));
        tick(); chk("sw_done_state", 32'(bus.state), 32'd0);
        chk("sw_done_flags", {bus.illegal, bus.bus_err}, 32'h0);
        chk("sw_done_ret", bus.retired, 32'd1);

        // reset mid-fetch drops the request asynchronously
        bus.mem_ready = 1'b0;
        #1; chk("mid_fetch_re", 32'(bus.mem_re), 32'd1);
        rst = 1'b1;
        #1; chk("mid_rst_ctl", 32'(obs()), 32'(mk(0,0,0,0,0,0,0,0,0,0)));
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
